// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, arctangent table and state type for the cosine CORDIC
package cordic_pkg;

  localparam int CORDIC_WIDTH = 22;
  localparam int CORDIC_GUARD = 2;
  localparam int CORDIC_ITER  = 22;
  localparam int CORDIC_FRAC  = CORDIC_WIDTH + CORDIC_GUARD;

  // 0.6072529350 scaled by 2^24; preloaded so no post-rotation gain correction is needed
  localparam logic signed [31:0] K_GAIN = 32'sd10188014;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_FINISH
  } cordic_state_e;

  // atan(2^-i) scaled by 2^24 and rounded; beyond i=7 the entry equals 2^(24-i) after rounding
  function automatic logic signed [31:0] atan_entry(input int idx);
    case (idx)
      0:       atan_entry = 32'sd13176795;
      1:       atan_entry = 32'sd7778716;
      2:       atan_entry = 32'sd4110060;
      3:       atan_entry = 32'sd2086331;
      4:       atan_entry = 32'sd1047214;
      5:       atan_entry = 32'sd524117;
      6:       atan_entry = 32'sd262123;
      7:       atan_entry = 32'sd131069;
      default: atan_entry = (idx < CORDIC_FRAC) ? (32'sd1 <<< (CORDIC_FRAC - idx)) : 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one combinational rotation-mode CORDIC micro-rotation
module cordic_stage #(
  parameter int IW    = 26,
  parameter int IDX_W = 5
) (
  input  logic signed [IW-1:0]    x,
  input  logic signed [IW-1:0]    y,
  input  logic signed [IW-1:0]    z,
  input  logic        [IDX_W-1:0] i,
  input  logic signed [IW-1:0]    atan,
  output logic signed [IW-1:0]    x_nx,
  output logic signed [IW-1:0]    y_nx,
  output logic signed [IW-1:0]    z_nx
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  assign x_sh = x >>> i;
  assign y_sh = y >>> i;

  // z >= 0 rotates counter-clockwise (d = +1)
  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    if (!z[IW-1]) begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - atan;
    end else begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + atan;
    end
  end

endmodule

// File: rtl/cordic_cos_iter.sv
// rtl/cordic_cos_iter.sv - iterative CORDIC cosine, one micro-rotation per enabled cycle
module cordic_cos_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITER  = CORDIC_ITER,
  parameter int GUARD = CORDIC_GUARD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH+1:0] theta,
  output logic [WIDTH+1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int IW    = WIDTH + 2 + GUARD;
  localparam int IDX_W = $clog2(WIDTH + 1);

  typedef logic signed [IW-1:0] iw_t;
  typedef logic signed [IW:0]   ext_t;
  typedef logic [IDX_W-1:0]     idx_t;

  localparam idx_t LAST   = idx_t'(ITER - 1);
  localparam ext_t RND    = ext_t'(1 << (GUARD - 1));
  localparam ext_t SAT_HI = ext_t'(1 << WIDTH);
  localparam ext_t SAT_LO = -SAT_HI;

  cordic_state_e state, state_nx;
  iw_t  x, y, z, x_nx, y_nx, z_nx, atan_i;
  idx_t i;
  ext_t x_rnd, x_shr;
  logic [WIDTH+1:0] res_sat;

  assign atan_i = iw_t'(atan_entry(int'(i)));

  cordic_stage #(
    .IW   (IW),
    .IDX_W(IDX_W)
  ) u_stage (
    .x   (x),
    .y   (y),
    .z   (z),
    .i   (i),
    .atan(atan_i),
    .x_nx(x_nx),
    .y_nx(y_nx),
    .z_nx(z_nx)
  );

  // result is taken from the final rotation's output so it is valid on the done cycle
  always_comb begin
    x_rnd   = {x_nx[IW-1], x_nx} + RND;
    x_shr   = x_rnd >>> GUARD;
    res_sat = x_shr[WIDTH+1:0];
    if (x_shr > SAT_HI) begin
      res_sat = SAT_HI[WIDTH+1:0];
    end else if (x_shr < SAT_LO) begin
      res_sat = SAT_LO[WIDTH+1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_ROTATE;
      ST_ROTATE: if (i == LAST) state_nx = ST_FINISH;
      ST_FINISH: begin
        state_nx = ST_IDLE;
        done     = clk_en;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      i      <= '0;
      result <= '0;
    end else if (clk_en) begin
      if (state == ST_IDLE && start) begin
        x <= iw_t'(K_GAIN);
        y <= '0;
        z <= {theta, {GUARD{1'b0}}};
        i <= '0;
      end else if (state == ST_ROTATE) begin
        x <= x_nx;
        y <= y_nx;
        z <= z_nx;
        i <= i + idx_t'(1);
        if (i == LAST) result <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_cordic_cos_iter.sv
// tb/tb_cordic_cos_iter.sv - self-checking bench for cordic_cos_iter against a real-valued cosine model
module tb_cordic_cos_iter;

  localparam int WIDTH = 22;
  localparam int ITER  = 22;
  localparam int TOL   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [23:0] theta;
  logic [23:0] result;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start = 0;
  bit checking = 1'b0;

  bit          m_busy  = 1'b0;
  int          m_cnt   = 0;
  logic [23:0] m_th    = '0;
  int          m_result = 0;
  bit          m_exact = 1'b1;
  bit          e_busy, e_done;

  cordic_cos_iter #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .start (start),
    .theta (theta),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cos_q22(input logic [23:0] th);
    real a;
    a = real'($signed(th)) / 4194304.0;
    return int'($floor($cos(a) * 4194304.0 + 0.5));
  endfunction

  task automatic check_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic check_val(input string nm, input logic [23:0] act, input int exp, input int tol);
    int a, d;
    a = $signed(act);
    d = (a > exp) ? a - exp : exp - a;
    total++;
    if (d > tol || $isunknown(act)) begin
      bad++;
      $display("FAIL %s: got %0d (0x%06h) want %0d +/-%0d at cycle %0d", nm, a, act, exp, tol, cyc);
    end
  endtask

  // Model: an accepted operation spends ITER enabled cycles rotating, then one done cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_result = 0;
      m_exact = 1'b1;
    end else if (clk_en) begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_th   = theta;
        end
      end else if (m_cnt == ITER) begin
        m_busy = 1'b0;
      end else begin
        m_cnt++;
        if (m_cnt == ITER) begin
          m_result = cos_q22(m_th);
          m_exact  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      e_busy = !reset && m_busy;
      e_done = e_busy && (m_cnt == ITER) && clk_en;
      check_bit("cyc_busy", busy, e_busy);
      check_bit("cyc_done", done, e_done);
      if (reset || m_exact) check_val("cyc_result_zero", result, 0, 0);
      else                  check_val("cyc_result_model", result, m_result, TOL);
    end
  end

  task automatic start_op(input logic [23:0] th);
    @(posedge clk);
    #2;
    start = 1'b1;
    theta = th;
    @(posedge clk);
    #2;
    start   = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t_start + 1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_done: no done within 80 cycles");
  endtask

  task automatic op(input string nm, input logic [23:0] th, input int exp, input int exp_lat);
    int lat;
    start_op(th);
    wait_done(lat);
    check_val({nm, "_latency"}, 24'(lat), exp_lat, 0);
    check_val(nm, result, exp, TOL);
    @(negedge clk);
    check_bit({nm, "_busy_after"}, busy, 1'b0);
  endtask

  logic [23:0] vec [6] = '{24'h100000, 24'hF00000, 24'h333333, 24'hD9999A, 24'h3FFFFF, 24'h000001};

  initial begin
    int lat, n_done;
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    theta  = '0;
    #1;
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_val("reset_result", result, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    reset    = 1'b0;
    checking = 1'b1;

    op("cos_0",     24'h000000, 24'h400000, ITER + 1);
    op("cos_p0p5",  24'h200000, 24'h382A50, ITER + 1);
    op("cos_m0p5",  24'hE00000, 24'h382A50, ITER + 1);
    op("cos_p1",    24'h400000, 24'h229450, ITER + 1);
    op("cos_m1",    24'hC00000, 24'h229450, ITER + 1);
    foreach (vec[k]) op("cos_vec", vec[k], cos_q22(vec[k]), ITER + 1);

    // second start mid-rotation must be ignored
    start_op(24'h200000);
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    theta = 24'h400000;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(lat);
    check_val("midstart_latency", 24'(lat), ITER + 1, 0);
    check_val("midstart_result", result, 24'h382A50, TOL);
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("midstart_extra_done", 24'(n_done), 0, 0);
    check_bit("midstart_busy_low", busy, 1'b0);

    // start held during the done cycle is ignored, next cycle accepts
    start_op(24'h100000);
    repeat (22) @(posedge clk);
    #2;
    start = 1'b1;
    theta = 24'hC00000;
    #1;
    check_bit("done_cycle_done", done, 1'b1);
    @(posedge clk);
    #2;
    start = 1'b0;
    check_bit("start_on_done_ignored", busy, 1'b0);
    op("after_done", 24'hC00000, 24'h229450, ITER + 1);

    // five stalled cycles mid-rotation
    start_op(24'hE00000);
    repeat (7) @(posedge clk);
    #2;
    clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    clk_en = 1'b1;
    wait_done(lat);
    check_val("stall_latency", 24'(lat), ITER + 6, 0);
    check_val("stall_result", result, 24'h382A50, TOL);

    // asynchronous reset in the middle of a rotation
    start_op(24'h400000);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_bit("arst_busy", busy, 1'b0);
    check_bit("arst_done", done, 1'b0);
    check_val("arst_result", result, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    op("post_reset", 24'h200000, 24'h382A50, ITER + 1);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_cos_iter.md
# cordic_cos_iter

Iterative rotation-mode CORDIC engine that computes cos(theta) for a signed fixed-point angle. Sits directly downstream of the float-to-fixed unpacker: it consumes the unpacker's signed Q1.22 (24-bit) angle and returns cos(theta) in the same Q1.22 format. The fixed-to-float packing stage downstream handles output conversion. One rotation is performed per enabled clock cycle, under a start/done handshake compatible with a multi-cycle custom instruction.

## Interface
- WIDTH, 22: number of fractional bits. Data ports are WIDTH+2 bits: sign, one integer bit, WIDTH fractional bits.
- ITER, 22: number of CORDIC micro-rotations, 1..WIDTH.
- GUARD, 2: extra LSBs carried internally on x, y and z.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- clk_en  in  1  clock enable; when low, all registers hold
- start  in  1  single-cycle pulse; captures theta when idle
- theta  in  WIDTH+2  signed angle in radians, Q1.WIDTH, valid range [-1.0, +1.0]
- result  out  WIDTH+2  cos(theta), signed Q1.WIDTH
- done  out  1  one-cycle pulse; result is valid in the same cycle and holds until the next done
- busy  out  1  high from the cycle after an accepted start up to and including the done cycle

## Operation
- States: IDLE, ROTATE, FINISH.
- IDLE: when start=1 and clk_en=1, load the following, then go to ROTATE:
  - x = K, y = 0, z = theta, with each operand left-shifted by GUARD.
  - i = 0.
  - K = 0.6072529350 scaled by 2^(WIDTH+GUARD).
- ROTATE: each enabled cycle, with d = +1 if z >= 0, else -1, update x, y, z together:
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*atan(2^-i)
  - Then i' = i + 1.
  - Shifts are arithmetic.
  - Internal width is WIDTH+2+GUARD. No saturation is needed, because |x| and |y| stay at or below 1.0 for |theta| <= 1.
  - After the rotation with i = ITER-1, go to FINISH.
- FINISH: result = x rounded to nearest and truncated by GUARD bits, then saturated to [-2^WIDTH, 2^WIDTH]. Assert done for one cycle, then return to IDLE.
- start while not IDLE: ignored; theta is not re-captured.
- start in the same cycle as done: ignored. A new start is accepted the next cycle.
- theta outside [-1, +1]: the operation is still performed and the result is undefined but finite. The upstream range reduction guarantees the input range.
- clk_en low in any state: the state, the counter and all datapath registers freeze; done is not asserted.
- reset at any time, including mid-rotation: the state goes to IDLE, and i, x, y, z are cleared. result=0, done=0, busy=0.

## Timing
- Reset values: result=0, done=0, busy=0, state=IDLE.
- Latency: with clk_en held high, done is asserted ITER+1 cycles after the start cycle. That is 23 cycles at the defaults.
- Throughput: one operation per ITER+2 cycles, because the first start is accepted the cycle after done.
- result updates only on the done cycle.
- Required accuracy: |error| <= 4 LSB of Q1.WIDTH at the defaults.

## Structure
- Shared package cordic_pkg holds:
  - the ATAN table: ITER entries of atan(2^-i), scaled by 2^(WIDTH+GUARD) and rounded;
  - the gain constant K;
  - the state enum.
- Sub-module: cordic_stage, a combinational single micro-rotation that takes x, y, z, i and the atan entry and produces x', y', z'. It is instantiated once and reused every cycle.

## Test plan
- theta=0x000000, start -> done after 23 cycles; result 0x400000 ±4 LSB.
- theta=0x200000 (0.5) -> result 0x382A50 ±4 LSB. theta=0xE00000 (-0.5) -> the same value.
- theta=0x400000 (1.0) -> result 0x229450 ±4 LSB. theta=0xC00000 (-1.0) -> the same value.
- Second start pulsed mid-rotation with a different theta -> ignored. The first result is returned, done pulses exactly once, and busy drops after done.
- clk_en held low for 5 cycles mid-rotation -> done is delayed by exactly 5 cycles and the result is unchanged.
- reset asserted asynchronously at cycle 10 of a rotation -> busy, done and result read 0 immediately. A new start after release gives a correct result.
